// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clk_ctrl_multi clock-management slice.
// Holds the lock FSM encoding, default sizing and the channel-index width helper.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RUN       = 2'd2
    } state_e;

    localparam int DEF_DIV_W   = 8;
    localparam int DEF_RST_DIV = 9;

    // A single channel still needs a 1-bit index field on the config port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_ctrl_multi_if.sv
// Divider configuration port of clk_ctrl_multi.
// Handshake: a write transfers on every clk edge where cfg_valid && cfg_ready; cfg_ready never depends on cfg_valid.
interface clk_ctrl_multi_if
    import clk_ctrl_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int DIV_W    = DEF_DIV_W
) ();

    localparam int CH_W = ch_width(CHANNELS);

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clk_ctrl_div_chan.sv
// One clock-enable channel: programmable divider with glitch-free reload at wrap.
// Optional square-wave export is built only when CLK_CTRL_SQUARE_EN is defined.
module clk_ctrl_div_chan
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_W   = DEF_DIV_W,
    parameter int RST_DIV = DEF_RST_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr_en,
    input  logic [DIV_W-1:0] wr_div,
`ifdef CLK_CTRL_SQUARE_EN
    output logic             sq,
`endif
    output logic             ce
);

    localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;
    logic             wrap;
`ifdef CLK_CTRL_SQUARE_EN
    logic             sq_q, sq_d;
`endif

    always_comb begin
        wrap       = run && (cnt_q == div_act_q);
        cnt_d      = '0;
        ce_d       = 1'b0;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;

        if (run) begin
            if (wrap) begin
                ce_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        // Reload only at a wrap (or while stopped) so a period is never cut short.
        if (pend_q && (wrap || !run)) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
        end

        // A write landing on the wrap cycle becomes the next pending value.
        if (wr_en) begin
            div_pend_d = wr_div;
            pend_d     = 1'b1;
        end

`ifdef CLK_CTRL_SQUARE_EN
        sq_d = run && (cnt_q <= (div_act_q >> 1));
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_act_q  <= RST_DIV_V;
            div_pend_q <= RST_DIV_V;
            pend_q     <= 1'b0;
            ce_q       <= 1'b0;
`ifdef CLK_CTRL_SQUARE_EN
            sq_q       <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            ce_q       <= ce_d;
`ifdef CLK_CTRL_SQUARE_EN
            sq_q       <= sq_d;
`endif
        end
    end

    assign ce = ce_q;
`ifdef CLK_CTRL_SQUARE_EN
    assign sq = sq_q;
`endif

endmodule

// File: rtl/clk_ctrl_multi.sv
// PLL-side clock management: lock qualification, gated downstream reset and CHANNELS clock-enable dividers.
// Defining CLK_CTRL_SQUARE_EN adds the sq[] square-wave outputs for pin export.
module clk_ctrl_multi
    import clk_ctrl_pkg::*;
#(
    parameter int CHANNELS    = 3,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int LOCK_CYCLES = 16,
    parameter int RST_DIV     = DEF_RST_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pll_lock,
    clk_ctrl_multi_if.slave     cfg,
    output logic                locked,
    output logic                rst_out_n,
    output logic [CHANNELS-1:0] ce,
`ifdef CLK_CTRL_SQUARE_EN
    output logic [CHANNELS-1:0] sq,
`endif
    output state_e              dbg_state
);

    localparam int               CH_W    = ch_width(CHANNELS);
    localparam int               LC_W    = $clog2(LOCK_CYCLES);
    localparam logic [CH_W:0]    CH_LIM  = (CH_W + 1)'(CHANNELS);
    localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LOCK_CYCLES - 1);

    logic [1:0]      lock_sync_q, lock_sync_d;
    logic            lock_s;
    state_e          state_q, state_d;
    logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
    logic            locked_q, locked_d;
    logic            rst_out_n_q, rst_out_n_d;
    logic            ready_q, ready_d;
    logic            cfg_ready_w;
    logic            cfg_acc;
    logic            run;

    assign lock_sync_d = {lock_sync_q[0], pll_lock};
    assign lock_s      = lock_sync_q[1];
    assign ready_d     = 1'b1;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                lock_cnt_d = '0;
                if (lock_s) begin
                    state_d = FILTER;
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LC_LAST) begin
                    state_d = RUN;
                end else begin
                    lock_cnt_d = lock_cnt_q + LC_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d    = WAIT_LOCK;
                lock_cnt_d = '0;
            end
        endcase

        // Both drop together on lock loss; release trails locked by one cycle.
        locked_d    = (state_d == RUN);
        rst_out_n_d = locked_q && (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= 2'b00;
            state_q     <= WAIT_LOCK;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            rst_out_n_q <= rst_out_n_d;
            ready_q     <= ready_d;
        end
    end

    // Out-of-range channel indices are refused rather than aliased.
    assign cfg_ready_w   = ready_q && ({1'b0, cfg.cfg_ch} < CH_LIM);
    assign cfg.cfg_ready = cfg_ready_w;
    assign cfg_acc       = cfg.cfg_valid && cfg_ready_w;
    assign run           = (state_q == RUN);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic wr_en;
        assign wr_en = cfg_acc && (cfg.cfg_ch == CH_W'(i));

        clk_ctrl_div_chan #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .run    (run),
            .wr_en  (wr_en),
            .wr_div (cfg.cfg_div),
`ifdef CLK_CTRL_SQUARE_EN
            .sq     (sq[i]),
`endif
            .ce     (ce[i])
        );
    end

    assign locked    = locked_q;
    assign rst_out_n = rst_out_n_q;
    assign dbg_state = state_q;

endmodule

// File: doc/clk_ctrl_multi.md
Name: clk_ctrl_multi

Overview:
- Parametrised clock-management block that sits directly behind the PLL primitive wrapper.
- Qualifies the raw PLL lock and generates a lock-gated, synchronously released reset for downstream logic.
- Derives CHANNELS independent clock-enable strobes from the PLL output clock. Each channel's divider is runtime-programmable through a valid/ready config port, replacing fixed-divide PLL taps.
- All downstream logic runs on the single PLL clock and is gated by ce strobes. No derived clock nets.

Parameters:
- CHANNELS, 3, number of clock-enable channels (1..8).
- DIV_W, 8, divider width; channel period = div+1 cycles.
- LOCK_CYCLES, 16, consecutive cycles pll_lock must be high before release (>=2).
- RST_DIV, 9, reset divider value loaded into every channel.

Ports:
- clk  in  1  PLL output clock; sole clock.
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  raw PLL lock, asynchronous to clk.
- cfg_valid  in  1  divider update request.
- cfg_ready  out  1  update accepted this cycle when high with cfg_valid.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel.
- cfg_div  in  DIV_W  new divider value.
- locked  out  1  qualified lock.
- rst_out_n  out  1  downstream reset, active-low; asserts asynchronously, deasserts synchronously.
- ce  out  CHANNELS  one-cycle enable strobes.

Behaviour:
- Reset values: locked=0, rst_out_n=0, ce=0, cfg_ready=0.
- Reset state: all counters 0; all channel div registers = RST_DIV.
- pll_lock synchroniser: 2 flops, reset to 0.
- FSM states:
  - WAIT_LOCK (reset state):
    - lock_cnt cleared.
    - When synced lock=1, go to FILTER.
  - FILTER:
    - lock_cnt increments each cycle while synced lock=1.
    - Synced lock=0 → WAIT_LOCK.
    - lock_cnt==LOCK_CYCLES-1 → RUN.
  - RUN:
    - locked=1 registered on the cycle of entry.
    - rst_out_n=1 one cycle after locked.
    - Synced lock=0 → WAIT_LOCK next cycle, with locked=0 and rst_out_n=0 in that same cycle.
- Dividers:
  - Channel counters run only in RUN.
  - All counters are zeroed on entering RUN, so channels are phase-aligned.
  - ce[i]=1 for exactly one cycle when cnt[i]==div_act[i]; cnt wraps to 0 on that cycle.
  - ce[i] is registered. First strobe occurs div_act[i]+1 cycles after RUN entry.
  - div=0 → ce[i] held high every cycle in RUN.
  - Outside RUN, ce=0 and counters are held at 0.
- Config:
  - cfg_ready=1 in every state except reset. There is no backpressure except out-of-range channels.
  - An accepted write stores cfg_div into div_pend[cfg_ch] and sets pend[cfg_ch].
  - div_pend transfers to div_act only at that channel's wrap (glitch-free). When not in RUN, the transfer is immediate on the next cycle.
  - A second write before the transfer overwrites div_pend; last write wins.
  - cfg_ch>=CHANNELS: cfg_ready=0 for that request and the request is ignored.
- Simultaneous events:
  - Lock loss in the same cycle as a wrap: ce still pulses that cycle; the pending divider is applied.
  - Config write in the same cycle as a wrap: the pending value is transferred first; the new write becomes pending.
- rst_n assertion mid-operation: all outputs and state return to reset values immediately (async). Pending config is discarded.

Optional Feature:
- Macro CLK_CTRL_SQUARE_EN.
- When defined:
  - Adds output sq[CHANNELS]: registered ~50% duty waveforms, high for cnt<=div_act/2.
  - Intended for export on pins only, never used as a clock.
  - sq=0 outside RUN.
- When undefined: port absent, no logic.

Decomposition:
- Package clk_ctrl_pkg holds:
  - FSM state enum (WAIT_LOCK, FILTER, RUN).
  - Default DIV_W and RST_DIV constants.
  - A function for channel-index width.
- One sub-module, clk_ctrl_div_chan: counter, div_act/div_pend/pend registers, ce output (and sq under the macro). Instantiated CHANNELS times via generate.
- FSM and synchroniser stay in the top.

Test Plan:
1. Release rst_n, pll_lock=1 steady → locked rises exactly 2+LOCK_CYCLES+1 cycles after rst_n release (sync + filter); rst_out_n rises 1 cycle later; ce[0] first pulses 10 cycles after RUN entry, then every 10 cycles.
2. Lock glitch: pll_lock low for 1 cycle at filter count 10 → FSM returns to WAIT_LOCK; locked stays 0; the full LOCK_CYCLES is required afresh.
3. In RUN, write ch1 div=3 mid-period with RST_DIV=9 → the old 10-cycle period completes, then ce[1] period=4; ch0/ch2 unchanged.
4. Two writes to ch2 (div=5 then div=1) before the wrap → only div=1 is applied; period 2. cfg_ch=3 with CHANNELS=3 → cfg_ready=0, no change.
5. Drop pll_lock in RUN → locked=0 and rst_out_n=0 within 3 cycles, ce=0. On relock, all ce restart phase-aligned.
6. Assert rst_n mid-RUN with a pending write → all outputs 0 immediately; after release, div_act=RST_DIV everywhere. With CLK_CTRL_SQUARE_EN, div=9 gives sq high 5, low 5.
